// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: 1024-entry FIFO controller in front of a dual-port block RAM.
// Port A writes, port B reads, both on CLK. The RAM has a registered read port,
// so RD_VALID trails an accepted read by one cycle. All status flags are
// registered but computed from the next-state count, so they never lag COUNT.
//
// Handshake: a write is accepted (wr_acc) in any cycle with WR_EN high and FULL
// low; a read is accepted (rd_acc) in any cycle with RD_EN high and EMPTY low.
// Accepted requests drive the RAM enables combinationally in that same cycle.
// Rejected requests change nothing except setting the sticky OVERFLOW/UNDERFLOW.
module bram_fifo_ctrl #(
  parameter int AF_LEVEL = 1020,
  parameter int AE_LEVEL = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_EN,
  input  logic [35:0] WR_DATA,
  output logic        FULL,
  output logic        ALMOST_FULL,
  output logic        OVERFLOW,
  input  logic        RD_EN,
  output logic [35:0] RD_DATA,
  output logic        RD_VALID,
  output logic        EMPTY,
  output logic        ALMOST_EMPTY,
  output logic        UNDERFLOW,
  output logic [10:0] COUNT,
  output logic        RAM_WEN_A,
  output logic [3:0]  RAM_BE_A,
  output logic [14:0] RAM_ADDR_A,
  output logic [31:0] RAM_WDATA_A,
  output logic [3:0]  RAM_WPARITY_A,
  output logic        RAM_REN_B,
  output logic [14:0] RAM_ADDR_B,
  input  logic [31:0] RAM_RDATA_B,
  input  logic [3:0]  RAM_RPARITY_B
);

  localparam logic [10:0] LP_DEPTH = 11'd1024;
  localparam logic [10:0] LP_AF    = 11'(AF_LEVEL);
  localparam logic [10:0] LP_AE    = 11'(AE_LEVEL);

  logic [9:0]  r_wr_ptr;
  logic [9:0]  r_rd_ptr;
  logic [10:0] r_count;
  logic        r_full;
  logic        r_empty;
  logic        r_almost_full;
  logic        r_almost_empty;
  logic        r_overflow;
  logic        r_underflow;
  logic        r_rd_valid;

  logic        w_wr_acc;
  logic        w_rd_acc;
  logic [10:0] w_count_nxt;

  // Accepts are also masked by RESET so the RAM enables are quiet while reset is held.
  assign w_wr_acc = WR_EN & ~r_full  & ~RESET;
  assign w_rd_acc = RD_EN & ~r_empty & ~RESET;

  // Next-state count: +1 write only, -1 read only, unchanged for both or neither.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 11'd1;
      2'b01:   w_count_nxt = r_count - 11'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers advance on their own accept; 10-bit width gives the 1023 -> 0 wrap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 10'd1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 10'd1;
    end
  end

  // Count and level flags, all loaded from the next-state count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == LP_DEPTH);
      r_empty        <= (w_count_nxt == 11'd0);
      r_almost_full  <= (w_count_nxt >= LP_AF);
      r_almost_empty <= (w_count_nxt <= LP_AE);
    end
  end

  // Sticky error flags and the one-cycle read-valid pipeline stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (WR_EN & r_full);
      r_underflow <= r_underflow | (RD_EN & r_empty);
      r_rd_valid  <= w_rd_acc;
    end
  end

  assign FULL          = r_full;
  assign EMPTY         = r_empty;
  assign ALMOST_FULL   = r_almost_full;
  assign ALMOST_EMPTY  = r_almost_empty;
  assign OVERFLOW      = r_overflow;
  assign UNDERFLOW     = r_underflow;
  assign COUNT         = r_count;
  assign RD_VALID      = r_rd_valid;
  assign RD_DATA       = {RAM_RPARITY_B, RAM_RDATA_B};

  // RAM side: word pointers sit in address bits [14:5].
  assign RAM_WEN_A     = w_wr_acc;
  assign RAM_BE_A      = 4'b1111;
  assign RAM_ADDR_A    = {r_wr_ptr, 5'b00000};
  assign RAM_WDATA_A   = WR_DATA[31:0];
  assign RAM_WPARITY_A = WR_DATA[35:32];
  assign RAM_REN_B     = w_rd_acc;
  assign RAM_ADDR_B    = {r_rd_ptr, 5'b00000};

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl with a behavioural registered-read RAM attached.
module tb_bram_fifo_ctrl;

  logic        CLK;
  logic        RESET;
  logic        WR_EN;
  logic [35:0] WR_DATA;
  logic        FULL;
  logic        ALMOST_FULL;
  logic        OVERFLOW;
  logic        RD_EN;
  logic [35:0] RD_DATA;
  logic        RD_VALID;
  logic        EMPTY;
  logic        ALMOST_EMPTY;
  logic        UNDERFLOW;
  logic [10:0] COUNT;
  logic        RAM_WEN_A;
  logic [3:0]  RAM_BE_A;
  logic [14:0] RAM_ADDR_A;
  logic [31:0] RAM_WDATA_A;
  logic [3:0]  RAM_WPARITY_A;
  logic        RAM_REN_B;
  logic [14:0] RAM_ADDR_B;
  logic [31:0] RAM_RDATA_B;
  logic [3:0]  RAM_RPARITY_B;

  bram_fifo_ctrl #(.AF_LEVEL(1020), .AE_LEVEL(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .OVERFLOW(OVERFLOW), .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY), .UNDERFLOW(UNDERFLOW), .COUNT(COUNT),
    .RAM_WEN_A(RAM_WEN_A), .RAM_BE_A(RAM_BE_A), .RAM_ADDR_A(RAM_ADDR_A),
    .RAM_WDATA_A(RAM_WDATA_A), .RAM_WPARITY_A(RAM_WPARITY_A),
    .RAM_REN_B(RAM_REN_B), .RAM_ADDR_B(RAM_ADDR_B),
    .RAM_RDATA_B(RAM_RDATA_B), .RAM_RPARITY_B(RAM_RPARITY_B)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural block RAM: synchronous write on A, registered read on B.
  logic [35:0] mem [0:1023];
  always @(posedge CLK) begin
    if (RAM_WEN_A) mem[RAM_ADDR_A[14:5]] <= {RAM_WPARITY_A, RAM_WDATA_A};
    if (RAM_REN_B) {RAM_RPARITY_B, RAM_RDATA_B} <= mem[RAM_ADDR_B[14:5]];
  end

  // Scoreboard state
  logic [35:0] exp_q[$];
  logic [35:0] mdl_q[$];
  int          exp_cnt;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic wr, input logic [35:0] d, input logic rd);
    WR_EN   = wr;
    WR_DATA = d;
    RD_EN   = rd;
  endtask

  // One clock: the bench decides acceptance from its own occupancy model.
  task automatic tick();
    logic w_ok;
    logic r_ok;
    w_ok = WR_EN && (exp_cnt < 1024);
    r_ok = RD_EN && (exp_cnt > 0);
    @(posedge CLK);
    #1;
    if (r_ok) begin
      exp_q.push_back(mdl_q.pop_front());
      exp_cnt--;
    end
    if (w_ok) begin
      mdl_q.push_back(WR_DATA);
      exp_cnt++;
    end
    WR_EN = 1'b0;
    RD_EN = 1'b0;
  endtask

  // Monitor: every RD_VALID must match the next expected word.
  always @(negedge CLK) begin
    if (RD_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_valid_unexpected: got RD_VALID=1 data %h expected no read", RD_DATA);
      end else begin
        chk("rd_data", RD_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_count"},     36'(COUNT), 36'd0);
    chk({tag, "_empty"},     36'(EMPTY), 36'd1);
    chk({tag, "_ae"},        36'(ALMOST_EMPTY), 36'd1);
    chk({tag, "_full"},      36'(FULL), 36'd0);
    chk({tag, "_af"},        36'(ALMOST_FULL), 36'd0);
    chk({tag, "_overflow"},  36'(OVERFLOW), 36'd0);
    chk({tag, "_underflow"}, 36'(UNDERFLOW), 36'd0);
    chk({tag, "_rd_valid"},  36'(RD_VALID), 36'd0);
    chk({tag, "_ram_wen_a"}, 36'(RAM_WEN_A), 36'd0);
    chk({tag, "_ram_ren_b"}, 36'(RAM_REN_B), 36'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 0;
    RESET   = 1'b1;
    drive(1'b1, 36'h0, 1'b1);
    #3;
    chk_reset_values("reset");
    chk("ram_be_a", 36'(RAM_BE_A), 36'hf);
    #9;
    RESET = 1'b0;
    drive(1'b0, 36'h0, 1'b0);

    // Five words in, five out in order.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 36'h9_0000_0000 + 36'(i), 1'b0);
      #1;
      chk("wr5_ram_wen_a", 36'(RAM_WEN_A), 36'd1);
      chk("wr5_addr_a", 36'(RAM_ADDR_A), 36'((i - 1) * 32));
      chk("wr5_wdata", {RAM_WPARITY_A, RAM_WDATA_A}, 36'h9_0000_0000 + 36'(i));
      tick();
    end
    chk("wr5_count", 36'(COUNT), 36'd5);
    chk("wr5_ae", 36'(ALMOST_EMPTY), 36'd0);
    chk("wr5_empty", 36'(EMPTY), 36'd0);
    chk("wr5_rd_valid_idle", 36'(RD_VALID), 36'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 36'h0, 1'b1);
      #1;
      chk("rd5_ram_ren_b", 36'(RAM_REN_B), 36'd1);
      chk("rd5_addr_b", 36'(RAM_ADDR_B), 36'((i - 1) * 32));
      tick();
      chk("rd5_rd_valid", 36'(RD_VALID), 36'd1);
    end
    tick();
    chk("rd5_empty", 36'(EMPTY), 36'd1);
    chk("rd5_count", 36'(COUNT), 36'd0);
    chk("rd5_ae", 36'(ALMOST_EMPTY), 36'd1);
    chk("rd5_rd_valid_after", 36'(RD_VALID), 36'd0);

    // Fill: write pointer now at 5; 1024 writes wrap it back to 5.
    for (int k = 1; k <= 1024; k++) begin
      drive(1'b1, {4'(k), 32'hA000_0000 + 32'(k)}, 1'b0);
      tick();
      if (k == 4)    chk("fill_ae_at4", 36'(ALMOST_EMPTY), 36'd1);
      if (k == 5)    chk("fill_ae_at5", 36'(ALMOST_EMPTY), 36'd0);
      if (k == 1019) chk("fill_af_at1019", 36'(ALMOST_FULL), 36'd0);
      if (k == 1020) chk("fill_af_at1020", 36'(ALMOST_FULL), 36'd1);
      if (k == 1023) chk("fill_full_at1023", 36'(FULL), 36'd0);
    end
    chk("fill_full", 36'(FULL), 36'd1);
    chk("fill_count", 36'(COUNT), 36'd1024);
    chk("fill_overflow_clear", 36'(OVERFLOW), 36'd0);
    drive(1'b1, 36'hF_FFFF_FFFF, 1'b0);
    #1;
    chk("ovf_ram_wen_a", 36'(RAM_WEN_A), 36'd0);
    tick();
    chk("ovf_overflow", 36'(OVERFLOW), 36'd1);
    chk("ovf_count", 36'(COUNT), 36'd1024);

    // Full with both requests: read wins, write rejected.
    drive(1'b1, 36'hE_EEEE_EEEE, 1'b1);
    tick();
    chk("fullboth_count", 36'(COUNT), 36'd1023);
    chk("fullboth_full", 36'(FULL), 36'd0);
    chk("fullboth_overflow", 36'(OVERFLOW), 36'd1);

    // Drain the rest; both pointers end at 5 after wrapping.
    for (int k = 0; k < 1023; k++) begin
      drive(1'b0, 36'h0, 1'b1);
      tick();
    end
    chk("drain_empty", 36'(EMPTY), 36'd1);
    chk("drain_count", 36'(COUNT), 36'd0);
    chk("drain_underflow_clear", 36'(UNDERFLOW), 36'd0);

    // Empty with both requests: write wins, read rejected; then two more writes.
    drive(1'b1, 36'h3_0000_0100, 1'b1);
    #1;
    chk("emptyboth_addr_a", 36'(RAM_ADDR_A), 36'h00A0);
    chk("emptyboth_ram_ren_b", 36'(RAM_REN_B), 36'd0);
    tick();
    chk("emptyboth_count", 36'(COUNT), 36'd1);
    chk("emptyboth_underflow", 36'(UNDERFLOW), 36'd1);
    chk("emptyboth_rd_valid", 36'(RD_VALID), 36'd0);
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 36'h3_0000_0100 + 36'(i), 1'b0);
      #1;
      chk("refill_addr_a", 36'(RAM_ADDR_A), 36'h00A0 + 36'(i * 32));
      tick();
    end

    // Bring COUNT to 500, then reset with RD_EN held high.
    for (int k = 0; k < 498; k++) begin
      drive(1'b1, {4'h6, 32'(k)}, 1'b0);
      tick();
    end
    chk("pre_reset_count", 36'(COUNT), 36'd501);
    drive(1'b0, 36'h0, 1'b1);
    tick();
    chk("pre_reset_count500", 36'(COUNT), 36'd500);
    RD_EN = 1'b1;
    #1;
    RESET = 1'b1;
    exp_q.delete();
    mdl_q.delete();
    exp_cnt = 0;
    #1;
    chk_reset_values("midreset");
    @(posedge CLK);
    #1;
    chk("midreset_rd_valid_next", 36'(RD_VALID), 36'd0);
    chk("midreset_count_next", 36'(COUNT), 36'd0);
    RESET = 1'b0;
    RD_EN = 1'b0;

    // First write after reset lands at address 0 and reads back.
    drive(1'b1, 36'h7_1234_5678, 1'b0);
    #1;
    chk("post_reset_addr_a", 36'(RAM_ADDR_A), 36'h0000);
    tick();
    drive(1'b0, 36'h0, 1'b1);
    #1;
    chk("post_reset_addr_b", 36'(RAM_ADDR_B), 36'h0000);
    tick();
    tick();
    tick();
    chk("final_exp_q_empty", 36'(exp_q.size()), 36'd0);
    chk("final_empty", 36'(EMPTY), 36'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
